mac_job_scheduler: RTL and testbench

- Two-requester round-robin scheduler for one shared multiply-accumulate datapath.
- A job is a dot product: `len` operand pairs are streamed in from the granted requester, with an optional down-accumulate mode.
- The multiply result is registered before the accumulator.
- Sits between client blocks and the MAC; the final sum is returned with a tag through a valid/ready result port.

---
 rtl/mac_job_scheduler_if.sv | 40 ++++
 rtl/mac_job_scheduler.sv | 148 ++++++++++++++
 tb/tb_mac_job_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_job_scheduler_if.sv
// Bundle of client-side request/operand/result signals for the shared MAC scheduler.
// The master modport is the client side; the slave modport is the scheduler side.
interface mac_job_scheduler_if #(
   parameter int DW   = 8,
   parameter int ACCW = 20,
   parameter int LENW = 4
);
   logic            req0;
   logic            req1;
   logic [LENW-1:0] len0;
   logic [LENW-1:0] len1;
   logic            sub0;
   logic            sub1;
   logic [DW-1:0]   a0;
   logic [DW-1:0]   b0;
   logic [DW-1:0]   a1;
   logic [DW-1:0]   b1;
   logic            op_valid0;
   logic            op_valid1;
   logic            op_ready0;
   logic            op_ready1;
   logic [1:0]      gnt;
   logic            busy;
   logic [ACCW-1:0] res;
   logic            res_id;
   logic            res_valid;
   logic            res_ready;

   modport master (
      output req0, req1, len0, len1, sub0, sub1,
      output a0, b0, a1, b1, op_valid0, op_valid1, res_ready,
      input  op_ready0, op_ready1, gnt, busy, res, res_id, res_valid
   );

   modport slave (
      input  req0, req1, len0, len1, sub0, sub1,
      input  a0, b0, a1, b1, op_valid0, op_valid1, res_ready,
      output op_ready0, op_ready1, gnt, busy, res, res_id, res_valid
   );
endinterface

// File: rtl/mac_job_scheduler.sv
// Two-requester round-robin scheduler feeding one multiply-accumulate datapath.
// Products are registered one stage ahead of the accumulator; results leave through a valid/ready port.
module mac_job_scheduler #(
   parameter int DW   = 8,
   parameter int ACCW = 20,
   parameter int LENW = 4
) (
   input  logic               clk,
   input  logic               reset,
   mac_job_scheduler_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                sub_q, sub_d;
   logic [LENW-1:0]     count_q, count_d;
   logic                drain_q, drain_d;
   logic [2*DW-1:0]     prod_q, prod_d;
   logic                pv_q, pv_d;
   logic [ACCW-1:0]     acc_q, acc_d;

   logic [1:0]            req_v;
   logic [1:0]            opv_v;
   logic [1:0]            sub_v;
   logic [1:0]            op_ready_v;
   logic [1:0][LENW-1:0]  len_v;
   logic [1:0][DW-1:0]    a_v;
   logic [1:0][DW-1:0]    b_v;

   logic                  pick;
   logic                  hs;
   logic [2*DW-1:0]       mult;
   logic [ACCW-1:0]       prod_ext;

   assign req_v = {bus.req1, bus.req0};
   assign opv_v = {bus.op_valid1, bus.op_valid0};
   assign sub_v = {bus.sub1, bus.sub0};
   assign len_v = {bus.len1, bus.len0};
   assign a_v   = {bus.a1, bus.a0};
   assign b_v   = {bus.b1, bus.b0};

   // Only the owning lane ever sees op_ready; the other lane's operands are never looked at.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign op_ready_v[gi] = (state_q == S_STREAM) && (owner_q == 1'(gi));
      end
   endgenerate

   assign bus.op_ready0 = op_ready_v[0];
   assign bus.op_ready1 = op_ready_v[1];

   // On a tie the requester not served last wins; last_q resets to 1 so req0 wins first.
   assign pick     = (&req_v) ? ~last_q : req_v[1];
   assign hs       = op_ready_v[owner_q] & opv_v[owner_q];
   assign mult     = (2*DW)'(a_v[owner_q]) * (2*DW)'(b_v[owner_q]);
   assign prod_ext = ACCW'(prod_q);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      sub_d   = sub_q;
      count_d = count_q;
      drain_d = drain_q;
      prod_d  = prod_q;
      pv_d    = 1'b0;
      acc_d   = acc_q;

      // The accumulate stage runs in any state whenever the product register holds a valid term.
      if (pv_q) begin
         acc_d = sub_q ? (acc_q - prod_ext) : (acc_q + prod_ext);
      end

      case (state_q)
         S_IDLE: begin
            if (|req_v) begin
               owner_d = pick;
               count_d = len_v[pick];
               sub_d   = sub_v[pick];
               acc_d   = '0;
               state_d = (len_v[pick] == '0) ? S_DONE : S_STREAM;
            end
         end
         S_STREAM: begin
            if (hs) begin
               prod_d  = mult;
               pv_d    = 1'b1;
               count_d = count_q - LENW'(1);
               if (count_q == LENW'(1)) begin
                  state_d = S_DRAIN;
                  drain_d = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q) begin
               state_d = S_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         sub_q   <= 1'b0;
         count_q <= '0;
         drain_q <= 1'b0;
         prod_q  <= '0;
         pv_q    <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         sub_q   <= sub_d;
         count_q <= count_d;
         drain_q <= drain_d;
         prod_q  <= prod_d;
         pv_q    <= pv_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.gnt       = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
   assign bus.res       = acc_q;
   assign bus.res_id    = owner_q;
   assign bus.res_valid = (state_q == S_DONE);
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares them on every result handshake.
module tb_mac_job_scheduler;
   logic clk;
   logic reset;
   int   cyc;
   int   errors;
   int   checks;

   int   exp_res[$];
   int   exp_id[$];
   int   pa[16];
   int   pb[16];

   mac_job_scheduler_if bus ();

   mac_job_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every result handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset && bus.res_valid && bus.res_ready) begin
         if (exp_res.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            automatic int er = exp_res.pop_front();
            automatic int ei = exp_id.pop_front();
            check("res", bus.res, er);
            check("res_id", bus.res_id, ei);
            $display("result res=%0d res_id=%0d expected res=%0d id=%0d", bus.res, bus.res_id, er, ei);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic set_ops(input int idx, input bit v, input int a, input int b);
      if (idx == 0) begin
         bus.op_valid0 = v; bus.a0 = 8'(a); bus.b0 = 8'(b);
      end else begin
         bus.op_valid1 = v; bus.a1 = 8'(a); bus.b1 = 8'(b);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic wait_gnt(input int exp);
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.gnt == 2'b00 && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      check("gnt", bus.gnt, exp);
   endtask

   task automatic stream(input int idx, input int n, input bit gaps, output int hs_cyc);
      int   k;
      int   guard;
      bit   v;
      logic rdy;
      logic ordy;
      k = 0; guard = 0; v = 1'b1; hs_cyc = -1;
      while (k < n && guard < 100) begin
         guard++;
         set_ops(idx, v, pa[k], pb[k]);
         @(negedge clk);
         rdy  = (idx != 0) ? bus.op_ready1 : bus.op_ready0;
         ordy = (idx != 0) ? bus.op_ready0 : bus.op_ready1;
         check("gnt_in_job", bus.gnt, (idx != 0) ? 2 : 1);
         check("other_op_ready", ordy, 0);
         if (v && rdy) begin
            hs_cyc = cyc;
            k++;
         end
         @(posedge clk); #1;
         if (gaps) v = ~v;
      end
      if (k < n) check("stream_timeout", k, n);
      set_ops(idx, 1'b0, 0, 0);
   endtask

   task automatic await_result(input int hs_cyc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.res_valid && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      check("res_valid_seen", bus.res_valid, 1);
      check("res_latency", cyc - hs_cyc, 3);
   endtask

   task automatic after_result();
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_gnt", bus.gnt, 0);
      check("idle_res_valid", bus.res_valid, 0);
      check("idle_busy", bus.busy, 0);
   endtask

   initial begin
      int hs;
      errors = 0; checks = 0;
      bus.req0 = 0; bus.req1 = 0; bus.len0 = 0; bus.len1 = 0;
      bus.sub0 = 0; bus.sub1 = 0; bus.res_ready = 1;
      set_ops(0, 0, 0, 0);
      set_ops(1, 0, 0, 0);
      do_reset();
      @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res", bus.res, 0);
      check("rst_op_ready0", bus.op_ready0, 0);
      check("rst_op_ready1", bus.op_ready1, 0);
      @(posedge clk); #1;

      // 1: 2*5 + 3*6 + 4*7 = 56
      exp_res.push_back(56); exp_id.push_back(0);
      bus.len0 = 3; bus.sub0 = 0; bus.req0 = 1;
      wait_gnt(1);
      @(posedge clk); #1; bus.req0 = 0;
      pa[0] = 2; pb[0] = 5; pa[1] = 3; pb[1] = 6; pa[2] = 4; pb[2] = 7;
      stream(0, 3, 1'b0, hs);
      await_result(hs);
      check("t1_gnt_at_result", bus.gnt, 1);
      after_result();

      // 2: simultaneous requests after reset; req0 len 1 (4*4=16), req1 len 2 (255*255*2)
      do_reset();
      exp_res.push_back(16); exp_id.push_back(0);
      exp_res.push_back(130050); exp_id.push_back(1);
      bus.len0 = 1; bus.sub0 = 0; bus.len1 = 2; bus.sub1 = 0;
      bus.req0 = 1; bus.req1 = 1;
      wait_gnt(1);
      @(posedge clk); #1; bus.req0 = 0;
      pa[0] = 4; pb[0] = 4;
      stream(0, 1, 1'b0, hs);
      await_result(hs);
      after_result();
      wait_gnt(2);
      @(posedge clk); #1; bus.req1 = 0;
      pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255;
      stream(1, 2, 1'b0, hs);
      await_result(hs);
      after_result();

      // 3: subtract mode wraps: 0 - 1 - 2 = 2^20 - 3
      exp_res.push_back(1048573); exp_id.push_back(1);
      bus.len1 = 2; bus.sub1 = 1; bus.req1 = 1;
      wait_gnt(2);
      @(posedge clk); #1; bus.req1 = 0;
      pa[0] = 1; pb[0] = 1; pa[1] = 2; pb[1] = 1;
      stream(1, 2, 1'b0, hs);
      await_result(hs);
      after_result();

      // 4: zero-length job goes straight to DONE
      exp_res.push_back(0); exp_id.push_back(0);
      bus.len0 = 0; bus.sub0 = 0; bus.req0 = 1;
      wait_gnt(1);
      check("t4_res_valid_with_gnt", bus.res_valid, 1);
      @(posedge clk); #1; bus.req0 = 0;
      @(negedge clk);
      check("t4_idle_busy", bus.busy, 0);
      check("t4_idle_gnt", bus.gnt, 0);
      @(posedge clk); #1;

      // 5: bubbles on op_valid plus result backpressure with req1 pending
      exp_res.push_back(223); exp_id.push_back(0);
      exp_res.push_back(30); exp_id.push_back(1);
      bus.res_ready = 0;
      bus.len0 = 3; bus.sub0 = 0; bus.req0 = 1;
      wait_gnt(1);
      @(posedge clk); #1; bus.req0 = 0;
      bus.len1 = 1; bus.sub1 = 0; bus.req1 = 1;
      pa[0] = 10; pb[0] = 10; pa[1] = 20; pb[1] = 3; pa[2] = 7; pb[2] = 9;
      stream(0, 3, 1'b1, hs);
      await_result(hs);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("hold_res", bus.res, 223);
         check("hold_res_id", bus.res_id, 0);
         check("hold_res_valid", bus.res_valid, 1);
         check("hold_gnt", bus.gnt, 1);
      end
      @(posedge clk); #1; bus.res_ready = 1;
      @(negedge clk);
      after_result();
      wait_gnt(2);
      @(posedge clk); #1; bus.req1 = 0;
      pa[0] = 5; pb[0] = 6;
      stream(1, 1, 1'b0, hs);
      await_result(hs);
      after_result();

      // 6: abort mid-STREAM with reset, then a clean job
      bus.len0 = 3; bus.sub0 = 0; bus.req0 = 1;
      wait_gnt(1);
      @(posedge clk); #1; bus.req0 = 0;
      set_ops(0, 1, 9, 9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      set_ops(0, 0, 0, 0);
      @(negedge clk);
      check("abort_gnt", bus.gnt, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_res_valid", bus.res_valid, 0);
      @(posedge clk); #1;
      exp_res.push_back(9); exp_id.push_back(0);
      bus.len0 = 1; bus.sub0 = 0; bus.req0 = 1;
      wait_gnt(1);
      @(posedge clk); #1; bus.req0 = 0;
      pa[0] = 3; pb[0] = 3;
      stream(0, 1, 1'b0, hs);
      await_result(hs);
      after_result();

      check("scoreboard_drained", exp_res.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
